// File: rtl/seq_mult32.sv
// Unsigned 32x32->64 shift-and-add multiplier driving one FADDER32 per iteration.
// Optional early termination on exhausted multiplier bits: define SEQ_MULT_EARLY_EXIT_EN.
module FADDER32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CarryIn,
  output logic [31:0] Sum,
  output logic        CarryOut
);
  logic [32:0] w_c;

  assign w_c[0] = CarryIn;
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign Sum[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end
  assign CarryOut = w_c[32];
endmodule

module seq_mult32 #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  if (WIDTH != 32) begin : g_bad_width
    $error("seq_mult32: WIDTH must be 32 (fixed FADDER32)");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_acc, r_mq, r_mcand;
  logic [5:0]  r_cnt;
  logic [63:0] r_product;
  logic [31:0] w_acc_nxt, w_mq_nxt, w_mcand_nxt;
  logic [5:0]  w_cnt_nxt;
  logic [63:0] w_product_nxt;
  logic [31:0] w_sum;
  logic        w_carry;

  FADDER32 u_fadder (
    .A        (r_acc),
    .B        (r_mq[0] ? r_mcand : 32'd0),
    .CarryIn  (1'b0),
    .Sum      (w_sum),
    .CarryOut (w_carry)
  );

`ifdef SEQ_MULT_EARLY_EXIT_EN
  logic [5:0]  w_rem;
  logic [31:0] w_mask;
  logic [63:0] w_skip;
  assign w_rem  = 6'd32 - r_cnt;
  // Low rem bits of mq are the multiplier bits not yet consumed.
  assign w_mask = 32'hFFFF_FFFF >> r_cnt;
  assign w_skip = {r_acc, r_mq} >> w_rem;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_mq_nxt      = r_mq;
    w_mcand_nxt   = r_mcand;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_mcand_nxt = a;
          w_mq_nxt    = b;
          w_acc_nxt   = 32'd0;
          w_cnt_nxt   = 6'd0;
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Carry re-enters at acc[31] so the 65-bit partial sum is never truncated.
        w_acc_nxt = {w_carry, w_sum[31:1]};
        w_mq_nxt  = {w_sum[0], r_mq[31:1]};
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == 6'd31) begin
          w_product_nxt = {w_acc_nxt, w_mq_nxt};
          w_state_nxt   = ST_DONE;
        end
`ifdef SEQ_MULT_EARLY_EXIT_EN
        if ((r_mq & w_mask) == 32'd0) begin
          {w_acc_nxt, w_mq_nxt} = w_skip;
          w_product_nxt         = w_skip;
          w_cnt_nxt             = 6'd32;
          w_state_nxt           = ST_DONE;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_acc     <= 32'd0;
      r_mq      <= 32'd0;
      r_mcand   <= 32'd0;
      r_cnt     <= 6'd0;
      r_product <= 64'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_mq      <= w_mq_nxt;
      r_mcand   <= w_mcand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
    end
  end

  assign busy    = (r_state == ST_BUSY);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;
endmodule
